// File: rtl/reset_sequencer_if.sv
// Reset sequencer signal bundle: reset causes in, sequenced resets and status out.
// The sequencer connects through the slave modport; whatever drives the causes
// and consumes the resets (board logic, testbench) uses the master modport.
interface reset_sequencer_if #(
   parameter int N_OUTS = 3
);
   logic              pll_locked;
   logic              btn_resetn;
   logic              sw_rst_req;
   logic [N_OUTS-1:0] rst_out_n;
   logic              rst_done;
   logic [1:0]        rst_cause;

   modport master (
      output pll_locked, btn_resetn, sw_rst_req,
      input  rst_out_n, rst_done, rst_cause
   );

   modport slave (
      input  pll_locked, btn_resetn, sw_rst_req,
      output rst_out_n, rst_done, rst_cause
   );
endinterface

// File: rtl/reset_sequencer.sv
// Board-level reset sequencer.
// Merges power-on, PLL lock loss, push-button and software reset causes,
// stretches every reset to HOLD_CYCLES, waits for lock and a released button,
// then releases the outputs one by one, STAGE_GAP cycles apart, bit 0 first.
// All outputs come straight from flops.
module reset_sequencer #(
   parameter int N_OUTS          = 3,
   parameter int HOLD_CYCLES     = 64,
   parameter int STAGE_GAP       = 16,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input logic              clk,
   input logic              resetn,
   reset_sequencer_if.slave bus
);

   localparam int HW  = $clog2(HOLD_CYCLES + 1);
   localparam int GW  = $clog2(STAGE_GAP + 1);
   localparam int DW  = $clog2(DEBOUNCE_CYCLES);
   localparam int STW = (N_OUTS > 1) ? $clog2(N_OUTS) : 1;

   localparam logic [HW-1:0]     HOLD_LAST  = HW'(HOLD_CYCLES - 1);
   localparam logic [GW-1:0]     GAP_LAST   = GW'(STAGE_GAP - 1);
   localparam logic [DW-1:0]     DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [STW-1:0]    STAGE_LAST = STW'(N_OUTS - 1);
   localparam logic [N_OUTS-1:0] OUT_LSB    = N_OUTS'(1);

   typedef enum logic [1:0] {
      S_HOLD,
      S_WAIT_LOCK,
      S_RELEASE,
      S_RUN
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_POR = 2'd0,
      CAUSE_PLL = 2'd1,
      CAUSE_BTN = 2'd2,
      CAUSE_SW  = 2'd3
   } cause_e;

   logic pll_meta, pll_sync;
   logic btn_meta, btn_sync;
   logic btn_db;
   logic [DW-1:0] db_cnt;

   state_e            state_q, state_d;
   logic [HW-1:0]     hold_q, hold_d;
   logic [GW-1:0]     gap_q, gap_d;
   logic [STW-1:0]    stage_q, stage_d;
   logic [N_OUTS-1:0] out_q, out_d;
   logic              done_q, done_d;
   cause_e            cause_q, cause_d;

   logic trig_pll, trig_btn, trig_sw, trig_any;

   // Two-flop synchronizers; PLL assumed unlocked, button assumed released.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would collapse the two stages into one.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pll_meta <= 1'b0;
         pll_sync <= 1'b0;
         btn_meta <= 1'b1;
         btn_sync <= 1'b1;
      end else begin
         pll_meta <= bus.pll_locked;
         pll_sync <= pll_meta;
         btn_meta <= bus.btn_resetn;
         btn_sync <= btn_meta;
      end
   end

   // Debounce: accept a new button level only after DEBOUNCE_CYCLES of disagreement.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         btn_db <= 1'b1;
         db_cnt <= '0;
      end else if (btn_sync != btn_db) begin
         if (db_cnt == DB_LAST) begin
            btn_db <= btn_sync;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + DW'(1);
         end
      end else begin
         db_cnt <= '0;
      end
   end

   assign trig_pll = ~pll_sync;
   assign trig_btn = ~btn_db;
   assign trig_sw  = bus.sw_rst_req;
   assign trig_any = trig_pll | trig_btn | trig_sw;

   // FSM and output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_HOLD;
         hold_q  <= '0;
         gap_q   <= '0;
         stage_q <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
         cause_q <= CAUSE_POR;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         gap_q   <= gap_d;
         stage_q <= stage_d;
         out_q   <= out_d;
         done_q  <= done_d;
         cause_q <= cause_d;
      end
   end

   // Next-state logic: stretch, wait for lock, staged release, watch for triggers.
   // NOTE: every variable gets its hold value first so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      gap_d   = gap_q;
      stage_d = stage_q;
      out_d   = out_q;
      done_d  = done_q;
      cause_d = cause_q;

      case (state_q)
         S_HOLD: begin
            out_d  = '0;
            done_d = 1'b0;
            if (hold_q == HOLD_LAST) begin
               hold_d  = '0;
               state_d = S_WAIT_LOCK;
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end

         S_WAIT_LOCK: begin
            if (trig_sw) begin
               state_d = S_HOLD;
               hold_d  = '0;
               cause_d = CAUSE_SW;
            end else if (pll_sync && btn_db) begin
               state_d = S_RELEASE;
               stage_d = '0;
               gap_d   = '0;
            end
         end

         S_RELEASE, S_RUN: begin
            if (trig_any) begin
               state_d = S_HOLD;
               hold_d  = '0;
               out_d   = '0;
               done_d  = 1'b0;
               cause_d = trig_pll ? CAUSE_PLL : (trig_btn ? CAUSE_BTN : CAUSE_SW);
            end else if (state_q == S_RELEASE) begin
               if (gap_q == GAP_LAST) begin
                  gap_d = '0;
                  // Outputs release strictly in order, so the next one is a shift-in.
                  out_d = (out_q << 1) | OUT_LSB;
                  if (stage_q == STAGE_LAST) begin
                     state_d = S_RUN;
                     done_d  = 1'b1;
                  end else begin
                     stage_d = stage_q + STW'(1);
                  end
               end else begin
                  gap_d = gap_q + GW'(1);
               end
            end
         end

         default: state_d = S_HOLD;
      endcase
   end

   assign bus.rst_out_n = out_q;
   assign bus.rst_done  = done_q;
   assign bus.rst_cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer (N_OUTS=3, HOLD=4, GAP=2, DEBOUNCE=8).
// A behavioural model tracks every cycle; a table and a few directed sequences
// pin down the documented timing, then random cause traffic exercises the rest.
module tb_reset_sequencer;

   localparam int N    = 3;
   localparam int HOLD = 4;
   localparam int GAP  = 2;
   localparam int DB   = 8;

   logic clk    = 1'b0;
   logic resetn = 1'b1;
   logic chk_en = 1'b0;
   int   total  = 0;
   int   bad    = 0;

   reset_sequencer_if #(.N_OUTS(N)) bus ();

   reset_sequencer #(
      .N_OUTS(N), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP), .DEBOUNCE_CYCLES(DB)
   ) dut (
      .clk(clk), .resetn(resetn), .bus(bus)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // phase: 0 stretching, 1 waiting for lock/button, 2 releasing or running.
   // t counts cycles since the wait ended; output k is free once t >= (k+1)*GAP.
   typedef struct {
      bit       pll_d1, pll_d2;
      bit       btn_d1, btn_d2;
      bit       btn_ok;
      int       streak;
      int       phase;
      int       held;
      int       t;
      bit [1:0] cause;
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t s;
      s.pll_d1 = 0; s.pll_d2 = 0;
      s.btn_d1 = 1; s.btn_d2 = 1; s.btn_ok = 1;
      s.streak = 0; s.phase = 0; s.held = 0; s.t = 0; s.cause = 0;
      return s;
   endfunction

   function automatic model_t model_step(model_t s, bit pll, bit btn, bit sw);
      model_t n = s;
      if (s.phase == 0) begin
         if (s.held + 1 == HOLD) begin n.phase = 1; n.held = 0; end
         else n.held = s.held + 1;
      end else if (s.phase == 1) begin
         if (sw) begin n.phase = 0; n.held = 0; n.cause = 3; end
         else if (s.pll_d2 && s.btn_ok) begin n.phase = 2; n.t = 0; end
      end else begin
         if (!s.pll_d2 || !s.btn_ok || sw) begin
            n.phase = 0; n.held = 0;
            n.cause = !s.pll_d2 ? 2'd1 : (!s.btn_ok ? 2'd2 : 2'd3);
         end else if (s.t < N * GAP) begin
            n.t = s.t + 1;
         end
      end
      n.pll_d1 = pll; n.pll_d2 = s.pll_d1;
      n.btn_d1 = btn; n.btn_d2 = s.btn_d1;
      if (s.btn_d2 != s.btn_ok) begin
         n.streak = s.streak + 1;
         if (n.streak == DB) begin n.btn_ok = s.btn_d2; n.streak = 0; end
      end else begin
         n.streak = 0;
      end
      return n;
   endfunction

   function automatic logic [N-1:0] exp_out(model_t s);
      logic [N-1:0] r = '0;
      for (int k = 0; k < N; k++) r[k] = (s.phase == 2) && (s.t >= (k + 1) * GAP);
      return r;
   endfunction

   always @(posedge clk or negedge resetn) begin
      if (!resetn) m <= model_reset();
      else         m <= model_step(m, bus.pll_locked, bus.btn_resetn, bus.sw_rst_req);
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_rst_out_n", 32'(bus.rst_out_n), 32'(exp_out(m)));
         check("model_rst_done", 32'(bus.rst_done), 32'((m.phase == 2) && (m.t >= N * GAP)));
         check("model_rst_cause", 32'(bus.rst_cause), 32'(m.cause));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input logic val, input int budget, input string name);
      int n = 0;
      while (bus.rst_done !== val && n < budget) begin tick(); n++; end
      check(name, 32'(bus.rst_done), 32'(val));
   endtask

   task automatic wait_out(input logic [N-1:0] val, input int budget, input string name);
      int n = 0;
      while (bus.rst_out_n !== val && n < budget) begin tick(); n++; end
      check(name, 32'(bus.rst_out_n), 32'(val));
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      bit           sw;
      logic [N-1:0] out;
      bit           done;
      logic [1:0]   cause;
   } vec_t;

   vec_t tbl[22];

   int pll_low_left, btn_low_left, rst_low_left;

   initial begin
      // One row per edge after power-on release; pll and button stay high.
      tbl = '{
         '{0, 3'b000, 0, 2'd0}, '{0, 3'b000, 0, 2'd0}, '{0, 3'b000, 0, 2'd0},
         '{0, 3'b000, 0, 2'd0}, '{0, 3'b000, 0, 2'd0}, '{0, 3'b000, 0, 2'd0},
         '{0, 3'b001, 0, 2'd0}, '{0, 3'b001, 0, 2'd0}, '{0, 3'b011, 0, 2'd0},
         '{0, 3'b011, 0, 2'd0}, '{0, 3'b111, 1, 2'd0}, '{0, 3'b111, 1, 2'd0},
         '{1, 3'b000, 0, 2'd3}, '{0, 3'b000, 0, 2'd3}, '{0, 3'b000, 0, 2'd3},
         '{0, 3'b000, 0, 2'd3}, '{0, 3'b000, 0, 2'd3}, '{0, 3'b000, 0, 2'd3},
         '{0, 3'b000, 0, 2'd3}, '{0, 3'b001, 0, 2'd3}, '{1, 3'b000, 0, 2'd3},
         '{0, 3'b000, 0, 2'd3}
      };

      bus.pll_locked = 1'b1;
      bus.btn_resetn = 1'b1;
      bus.sw_rst_req = 1'b0;
      #2 resetn = 1'b0;
      repeat (5) tick();
      chk_en = 1'b1;
      check("por_rst_out_n", 32'(bus.rst_out_n), 32'h0);
      check("por_rst_done", 32'(bus.rst_done), 32'h0);
      check("por_rst_cause", 32'(bus.rst_cause), 32'h0);
      resetn = 1'b1;

      // POR release timing, then software request in RUN and at rst_out_n=001.
      for (int i = 0; i < 22; i++) begin
         bus.sw_rst_req = tbl[i].sw;
         tick();
         check($sformatf("tbl%0d_out", i), 32'(bus.rst_out_n), 32'(tbl[i].out));
         check($sformatf("tbl%0d_done", i), 32'(bus.rst_done), 32'(tbl[i].done));
         check($sformatf("tbl%0d_cause", i), 32'(bus.rst_cause), 32'(tbl[i].cause));
      end
      bus.sw_rst_req = 1'b0;
      wait_done(1'b1, 60, "run_after_sw");

      // PLL loss: outputs fall on the third edge.
      bus.pll_locked = 1'b0;
      tick(); check("pll_edge1_out", 32'(bus.rst_out_n), 32'h7);
      tick(); check("pll_edge2_out", 32'(bus.rst_out_n), 32'h7);
      tick(); check("pll_edge3_out", 32'(bus.rst_out_n), 32'h0);
      check("pll_cause", 32'(bus.rst_cause), 32'h1);
      repeat (7) tick();
      bus.pll_locked = 1'b1;
      wait_done(1'b1, 60, "pll_relock_run");

      // Button: short glitches are filtered, a long press resets.
      for (int g = 0; g < 3; g++) begin
         bus.btn_resetn = 1'b0;
         repeat (3) tick();
         bus.btn_resetn = 1'b1;
         repeat (6) tick();
      end
      check("btn_glitch_done", 32'(bus.rst_done), 32'h1);
      bus.btn_resetn = 1'b0;
      repeat (12) tick();
      check("btn_press_out", 32'(bus.rst_out_n), 32'h0);
      check("btn_press_cause", 32'(bus.rst_cause), 32'h2);
      bus.btn_resetn = 1'b1;
      repeat (8) tick();
      check("btn_still_held", 32'(bus.rst_done), 32'h0);
      wait_done(1'b1, 60, "btn_release_run");

      // PLL loss and software request reach the FSM together: PLL wins.
      bus.pll_locked = 1'b0;
      tick(); tick();
      bus.sw_rst_req = 1'b1;
      tick();
      bus.sw_rst_req = 1'b0;
      check("prio_cause", 32'(bus.rst_cause), 32'h1);
      check("prio_out", 32'(bus.rst_out_n), 32'h0);
      bus.pll_locked = 1'b1;
      wait_done(1'b1, 60, "prio_run");

      // Asynchronous power-on reset in the middle of the release.
      bus.sw_rst_req = 1'b1;
      tick();
      bus.sw_rst_req = 1'b0;
      wait_out(3'b011, 40, "mid_release_reached");
      #2 resetn = 1'b0;
      #1;
      check("async_out", 32'(bus.rst_out_n), 32'h0);
      check("async_done", 32'(bus.rst_done), 32'h0);
      check("async_cause", 32'(bus.rst_cause), 32'h0);
      tick(); tick();
      resetn = 1'b1;
      wait_done(1'b1, 60, "async_recover_run");

      // Random cause traffic, checked cycle by cycle against the model.
      pll_low_left = 0; btn_low_left = 0; rst_low_left = 0;
      for (int c = 0; c < 4000; c++) begin
         if (pll_low_left > 0) pll_low_left--;
         else if ($urandom_range(0, 99) == 0) pll_low_left = $urandom_range(1, 12);
         if (btn_low_left > 0) btn_low_left--;
         else if ($urandom_range(0, 79) == 0) btn_low_left = $urandom_range(1, 14);
         if (rst_low_left > 0) rst_low_left--;
         else if ($urandom_range(0, 999) == 0) rst_low_left = $urandom_range(1, 3);
         bus.pll_locked = (pll_low_left == 0);
         bus.btn_resetn = (btn_low_left == 0);
         bus.sw_rst_req = ($urandom_range(0, 59) == 0);
         resetn         = (rst_low_left == 0);
         tick();
      end
      bus.pll_locked = 1'b1;
      bus.btn_resetn = 1'b1;
      bus.sw_rst_req = 1'b0;
      resetn         = 1'b1;
      wait_done(1'b1, 80, "final_run");

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
